// File: rtl/simple_timer_core.sv
// Prescaled 64-bit tick counter with terminal-count expiry and free-running wrap.
// Driven by the timer register block; done/wrap are single-cycle event pulses.
module simple_timer_core #(
  parameter int unsigned prescale = 1,
  parameter int unsigned COUNT_W  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               srst,
  input  logic [COUNT_W-1:0] max_count,
  output logic               running,
  output logic [COUNT_W-1:0] current_count,
  output logic               done,
  output logic               wrap
);

  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] PRESC_LAST = PW'(prescale - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [COUNT_W-1:0] count_q, count_nxt;
  logic [PW-1:0]      presc_q, presc_nxt;
  logic               done_q, done_nxt;
  logic               wrap_q, wrap_nxt;
  logic               running_q;
  logic               tick;

  // The increment is done one bit wider so a count of all-ones cannot alias below the limit.
  function automatic logic reaches_max(input logic [COUNT_W-1:0] cnt,
                                       input logic [COUNT_W-1:0] lim);
    logic [COUNT_W:0] inc;
    inc = {1'b0, cnt} + {{COUNT_W{1'b0}}, 1'b1};
    return inc >= {1'b0, lim};
  endfunction

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    presc_nxt = presc_q;
    done_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    if (srst) begin
      state_nxt = IDLE;
      count_nxt = '0;
      presc_nxt = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) state_nxt = RUNNING;
        end
        RUNNING: begin
          // Dropping enable discards any tick on the same edge, including an expiring one.
          if (!enable) begin
            state_nxt = IDLE;
          end else begin
            presc_nxt = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              if (max_count == '0) begin
                count_nxt = count_q + COUNT_W'(1);
                wrap_nxt  = &count_q;
              end else if (reaches_max(count_q, max_count)) begin
                count_nxt = max_count;
                state_nxt = EXPIRED;
                done_nxt  = 1'b1;
              end else begin
                count_nxt = count_q + COUNT_W'(1);
              end
            end
          end
        end
        EXPIRED: begin
          state_nxt = EXPIRED;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      count_q   <= count_nxt;
      presc_q   <= presc_nxt;
      done_q    <= done_nxt;
      wrap_q    <= wrap_nxt;
      running_q <= (state_nxt == RUNNING);
    end
  end

  assign running       = running_q;
  assign current_count = count_q;
  assign done          = done_q;
  assign wrap          = wrap_q;

endmodule

// File: tb/tb_simple_timer_core.sv
// Bench for simple_timer_core: three instances (prescale 1, prescale 4, 4-bit wrap)
// compared every cycle against a behavioural model, plus hand-computed checkpoints.
module tb_simple_timer_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  logic en [3];
  logic sr [3];
  logic [63:0] mx [3];
  logic run [3];
  logic dn [3];
  logic wr [3];
  logic [63:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simple_timer_core #(.prescale(1), .COUNT_W(64)) u_p1 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .srst(sr[0]), .max_count(mx[0]),
    .running(run[0]), .current_count(cnt0), .done(dn[0]), .wrap(wr[0]));

  simple_timer_core #(.prescale(4), .COUNT_W(64)) u_p4 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .srst(sr[1]), .max_count(mx[1]),
    .running(run[1]), .current_count(cnt1), .done(dn[1]), .wrap(wr[1]));

  simple_timer_core #(.prescale(1), .COUNT_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .srst(sr[2]), .max_count(mx[2][3:0]),
    .running(run[2]), .current_count(cnt2), .done(dn[2]), .wrap(wr[2]));

  // Behavioural model: mode 0 idle, 1 running, 2 expired; phase counts clocks since last tick.
  int          m_mode [3] = '{0, 0, 0};
  int          m_ph   [3] = '{0, 0, 0};
  logic [63:0] m_cnt  [3] = '{64'd0, 64'd0, 64'd0};
  logic        m_done [3] = '{1'b0, 1'b0, 1'b0};
  logic        m_wrap [3] = '{1'b0, 1'b0, 1'b0};

  function automatic int pre_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic logic [63:0] top_of(input int i);
    return (i == 2) ? 64'hF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] act_cnt(input int i);
    if (i == 0) return cnt0;
    if (i == 1) return cnt1;
    return {60'd0, cnt2};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      logic [63:0] lim;
      lim = (i == 2) ? {60'd0, mx[2][3:0]} : mx[i];
      m_done[i] = 1'b0;
      m_wrap[i] = 1'b0;
      if (!rst_n || sr[i]) begin
        m_mode[i] = 0;
        m_ph[i]   = 0;
        m_cnt[i]  = 64'd0;
      end else if (m_mode[i] == 0) begin
        if (en[i]) m_mode[i] = 1;
      end else if (m_mode[i] == 1) begin
        if (!en[i]) begin
          m_mode[i] = 0;
        end else begin
          m_ph[i] = m_ph[i] + 1;
          if (m_ph[i] == pre_of(i)) begin
            m_ph[i] = 0;
            if (lim == 64'd0) begin
              if (m_cnt[i] == top_of(i)) begin
                m_cnt[i]  = 64'd0;
                m_wrap[i] = 1'b1;
              end else begin
                m_cnt[i] = m_cnt[i] + 64'd1;
              end
            end else if (({1'b0, m_cnt[i]} + 65'd1) >= {1'b0, lim}) begin
              m_cnt[i]  = lim;
              m_mode[i] = 2;
              m_done[i] = 1'b1;
            end else begin
              m_cnt[i] = m_cnt[i] + 64'd1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_running%0d", i), 64'(run[i]), 64'(m_mode[i] == 1));
        chk($sformatf("model_count%0d", i), act_cnt(i), m_cnt[i]);
        chk($sformatf("model_done%0d", i), 64'(dn[i]), 64'(m_done[i]));
        chk($sformatf("model_wrap%0d", i), 64'(wr[i]), 64'(m_wrap[i]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      sr[i] = 1'b0;
      mx[i] = 64'd0;
    end
    cyc(2);
    chk("reset_running", 64'(run[0]), 64'd0);
    chk("reset_count", cnt0, 64'd0);
    chk("reset_done", 64'(dn[0]), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    cyc(1);

    // prescale=1, max_count=5
    mx[0] = 64'd5; en[0] = 1'b1;
    cyc(1); chk("t1_running_k1", 64'(run[0]), 64'd1); chk("t1_count_k1", cnt0, 64'd0);
    cyc(2); chk("t1_count_k3", cnt0, 64'd2);
    cyc(3); chk("t1_count_k6", cnt0, 64'd5); chk("t1_done_k6", 64'(dn[0]), 64'd1);
            chk("t1_running_k6", 64'(run[0]), 64'd0);
    cyc(1); chk("t1_done_k7", 64'(dn[0]), 64'd0); chk("t1_hold_k7", cnt0, 64'd5);
            chk("t1_expired_k7", 64'(run[0]), 64'd0);

    // prescale=4, max_count=3 with a 10-cycle pause
    mx[1] = 64'd3; en[1] = 1'b1;
    cyc(5); chk("t2_count_k5", cnt1, 64'd1);
    cyc(1); en[1] = 1'b0;
    cyc(1); chk("t2_paused_run", 64'(run[1]), 64'd0); chk("t2_paused_cnt", cnt1, 64'd1);
    cyc(9); chk("t2_paused_cnt16", cnt1, 64'd1); en[1] = 1'b1;
    cyc(3); chk("t2_count_k19", cnt1, 64'd1); chk("t2_run_k19", 64'(run[1]), 64'd1);
    cyc(1); chk("t2_phase_kept", cnt1, 64'd2);
    cyc(4); chk("t2_count_k24", cnt1, 64'd3); chk("t2_done_k24", 64'(dn[1]), 64'd1);
            chk("t2_run_k24", 64'(run[1]), 64'd0);
    en[1] = 1'b0;

    // 4-bit free-running wrap
    mx[2] = 64'd0; en[2] = 1'b1;
    cyc(16); chk("t3_count_top", {60'd0, cnt2}, 64'd15); chk("t3_nowrap", 64'(wr[2]), 64'd0);
    cyc(1);  chk("t3_count_wrap", {60'd0, cnt2}, 64'd0); chk("t3_wrap", 64'(wr[2]), 64'd1);
             chk("t3_wrap_nodone", 64'(dn[2]), 64'd0);
    cyc(1);  chk("t3_wrap_pulse", 64'(wr[2]), 64'd0); chk("t3_count_after", {60'd0, cnt2}, 64'd1);
    en[2] = 1'b0;

    // srst from EXPIRED, then lower max_count below the count
    sr[0] = 1'b1; mx[0] = 64'd100;
    cyc(1); chk("t4_srst_cnt", cnt0, 64'd0); chk("t4_srst_run", 64'(run[0]), 64'd0);
    cyc(1); chk("t4_srst_hold", cnt0, 64'd0);
    sr[0] = 1'b0;
    cyc(1); chk("t4_restart_run", 64'(run[0]), 64'd1);
    cyc(1); chk("t4_restart_cnt", cnt0, 64'd1);
    cyc(9); chk("t4_cnt10", cnt0, 64'd10);
    mx[0] = 64'd4;
    cyc(1); chk("t4_lowered_cnt", cnt0, 64'd4); chk("t4_lowered_done", 64'(dn[0]), 64'd1);
            chk("t4_lowered_run", 64'(run[0]), 64'd0);

    // srst while RUNNING
    sr[0] = 1'b1; mx[0] = 64'd100;
    cyc(1); sr[0] = 1'b0;
    cyc(3); chk("t5_cnt2", cnt0, 64'd2);
    sr[0] = 1'b1;
    cyc(1); chk("t5_srst_cnt", cnt0, 64'd0); chk("t5_srst_run", 64'(run[0]), 64'd0);
            chk("t5_srst_done", 64'(dn[0]), 64'd0);
    sr[0] = 1'b0;

    // enable falls on the expiring tick
    mx[0] = 64'd3;
    cyc(3); chk("t6_cnt2", cnt0, 64'd2);
    en[0] = 1'b0;
    cyc(1); chk("t6_no_expire_cnt", cnt0, 64'd2); chk("t6_no_done", 64'(dn[0]), 64'd0);
            chk("t6_idle", 64'(run[0]), 64'd0);
    en[0] = 1'b1;
    cyc(1); chk("t6_resume_run", 64'(run[0]), 64'd1);
    cyc(1); chk("t6_expire_cnt", cnt0, 64'd3); chk("t6_expire_done", 64'(dn[0]), 64'd1);

    // free-running, then switch to a limit below the count
    sr[0] = 1'b1;
    cyc(1); sr[0] = 1'b0; mx[0] = 64'd0;
    cyc(6); chk("t7_free_cnt", cnt0, 64'd5);
    mx[0] = 64'd3;
    cyc(1); chk("t7_decrease_cnt", cnt0, 64'd3); chk("t7_decrease_done", 64'(dn[0]), 64'd1);
            chk("t7_decrease_wrap", 64'(wr[0]), 64'd0);
    sr[0] = 1'b1;
    cyc(1); sr[0] = 1'b0; mx[0] = 64'd0; en[1] = 1'b1; mx[1] = 64'd0;
    cyc(6);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    #1;
    chk("t8_async_run0", 64'(run[0]), 64'd0);
    chk("t8_async_cnt0", cnt0, 64'd0);
    chk("t8_async_run1", 64'(run[1]), 64'd0);
    chk("t8_async_cnt1", cnt1, 64'd0);
    #1 rst_n = 1'b1;
    cyc(1); chk("t8_stay_idle", 64'(run[0]), 64'd0); chk("t8_stay_cnt", cnt0, 64'd0);
    en[0] = 1'b1; mx[0] = 64'd2;
    cyc(1); chk("t8_start_run", 64'(run[0]), 64'd1);
    cyc(2); chk("t8_expire_cnt", cnt0, 64'd2); chk("t8_expire_done", 64'(dn[0]), 64'd1);
    cyc(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
